// File: rtl/decim_pkg.sv
// Shared constants for the decimating accumulator and its output buffer.
package decim_pkg;
  localparam int IN_W_DEF       = 16;
  localparam int RATIO_LOG2_DEF = 3;
  localparam int ACC_W          = IN_W_DEF + RATIO_LOG2_DEF;
  localparam int FIFO_DEPTH     = 2;
endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO; a push into a full FIFO succeeds only alongside a pop.
module sync_fifo2
  import decim_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] r_mem [FIFO_DEPTH];
  logic         r_wp, r_rp;
  logic [1:0]   r_cnt;
  logic         w_pop, w_push;

  assign empty  = (r_cnt == 2'd0);
  assign full   = (r_cnt == 2'(FIFO_DEPTH));
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign dout   = r_mem[r_rp];

  // When full, the write slot equals the head being popped, so the new entry lands behind the survivor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= din;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end
endmodule

// File: rtl/decim_accum.sv
// Sums R = 2**RATIO_LOG2 samples, emits the floored mean through a 2-entry buffer, flags drops.
module decim_accum
  import decim_pkg::*;
#(
  parameter int IN_W       = IN_W_DEF,
  parameter int RATIO_LOG2 = RATIO_LOG2_DEF,
  parameter int OUT_W      = IN_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    ovf,
  input  logic                    ovf_clr
);
  localparam int AW = IN_W + RATIO_LOG2;

  logic signed [AW-1:0]         r_acc;
  logic [RATIO_LOG2-1:0]        r_cnt;
  logic                         r_ovf;
  logic                         w_take, w_last, w_full, w_empty, w_drop;
  logic signed [AW-1:0]         w_sum, w_shift;
  logic signed [OUT_W-1:0]      w_res;

  assign w_take  = en & in_valid;
  assign w_last  = w_take & (r_cnt == '1);
  // AW bits hold R full-scale samples, so the sum cannot wrap.
  assign w_sum   = r_acc + {{RATIO_LOG2{in_data[IN_W-1]}}, in_data};
  assign w_shift = w_sum >>> RATIO_LOG2;
  assign w_res   = w_shift[OUT_W-1:0];
  assign w_drop  = w_last & w_full & ~(out_valid & out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (!en) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_take) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_last ? '0 : w_sum;
    end
  end

  // A drop wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ovf <= 1'b0;
    else     r_ovf <= (r_ovf & ~ovf_clr) | w_drop;
  end

  sync_fifo2 #(.W(OUT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_last),
    .pop   (out_ready),
    .din   (w_res),
    .dout  (out_data),
    .full  (w_full),
    .empty (w_empty)
  );

  assign out_valid = ~w_empty;
  assign ovf       = r_ovf;
endmodule

// File: tb/tb_decim_accum.sv
// Directed bench for decim_accum with hand-computed expectations.
module tb_decim_accum;
  logic               clk = 1'b0;
  logic               rst, en, in_valid, out_ready, ovf_clr;
  logic signed [15:0] in_data;
  logic               out_valid, ovf;
  logic signed [15:0] out_data;
  int                 errors = 0;
  int                 checks = 0;

  always #5 clk = ~clk;

  decim_accum dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, input int n);
    in_data  = 16'(v);
    in_valid = 1'b1;
    repeat (n) tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    #12;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_ovf", int'(ovf), 0);
    tick();
    rst = 1'b0;
    en  = 1'b1;
    out_ready = 1'b1;

    // Basic mean of 100, visible for one cycle only
    send(100, 7);
    chk("m100_early", int'(out_valid), 0);
    send(100, 1);
    chk("m100_valid", int'(out_valid), 1);
    chk("m100_data", int'(out_data), 100);
    tick();
    chk("m100_once", int'(out_valid), 0);

    // Floor and full-scale boundaries
    send(0, 7);
    send(-1, 1);
    chk("floor_data", int'(out_data), -1);
    tick();
    send(-32768, 8);
    chk("min_data", int'(out_data), -32768);
    tick();
    send(32767, 8);
    chk("max_data", int'(out_data), 32767);
    tick();
    chk("max_popped", int'(out_valid), 0);

    // Overflow: two held, third dropped
    out_ready = 1'b0;
    send(5, 23);
    chk("ovf_before", int'(ovf), 0);
    chk("hold_valid", int'(out_valid), 1);
    chk("hold_data", int'(out_data), 5);
    send(5, 1);
    chk("ovf_set", int'(ovf), 1);
    out_ready = 1'b1;
    tick();
    chk("pop1_valid", int'(out_valid), 1);
    chk("pop1_data", int'(out_data), 5);
    tick();
    chk("pop2_empty", int'(out_valid), 0);
    chk("ovf_sticky", int'(ovf), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", int'(ovf), 0);

    // Push and pop together while full
    out_ready = 1'b0;
    send(1, 8);
    send(2, 8);
    send(3, 7);
    out_ready = 1'b1;
    send(3, 1);
    out_ready = 1'b0;
    chk("pp_ovf", int'(ovf), 0);
    chk("pp_head", int'(out_data), 2);
    tick();
    chk("pp_stable", int'(out_data), 2);
    chk("pp_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    chk("pp_second", int'(out_data), 3);
    chk("pp_second_v", int'(out_valid), 1);
    tick();
    chk("pp_empty", int'(out_valid), 0);

    // Reset mid-window with buffered data
    out_ready = 1'b0;
    send(7, 8);
    chk("pre_rst_data", int'(out_data), 7);
    send(50, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_data", int'(out_data), 0);
    chk("arst_ovf", int'(ovf), 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    send(20, 5);
    chk("post_rst_none", int'(out_valid), 0);
    send(20, 3);
    chk("post_rst_valid", int'(out_valid), 1);
    chk("post_rst_data", int'(out_data), 20);
    tick();
    chk("post_rst_once", int'(out_valid), 0);

    // Enable drop aborts the partial window
    send(40, 5);
    en = 1'b0;
    tick();
    en = 1'b1;
    send(8, 3);
    chk("abort_none", int'(out_valid), 0);
    send(8, 5);
    chk("abort_valid", int'(out_valid), 1);
    chk("abort_data", int'(out_data), 8);
    tick();
    chk("abort_once", int'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
